// File: rtl/pll_loop_ctrl.sv
// pll_loop_ctrl: digital phase detector and saturating PI loop filter that
// steers the DCO tuning word from the reference/feedback edge separation and
// reports loop lock.
module pll_loop_ctrl #(
    parameter int                   BIT_COUNT  = 24,
    parameter int                   ERR_W      = 16,
    parameter int                   KP_SHIFT   = 8,
    parameter int                   KI_SHIFT   = 4,
    parameter logic [BIT_COUNT-1:0] SPEED_INIT = 24'h100000,
    parameter logic [BIT_COUNT-1:0] SPEED_MIN  = 24'h010000,
    parameter logic [BIT_COUNT-1:0] SPEED_MAX  = 24'h7FFFFF,
    parameter int                   LOCK_TOL   = 2,
    parameter int                   LOCK_CNT   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    ref_in,
    input  logic                    fb_in,
    output logic [BIT_COUNT-1:0]    speed_var,
    output logic                    upd,
    output logic signed [ERR_W-1:0] phase_err,
    output logic                    locked
);

    localparam int W    = BIT_COUNT + ERR_W + 2;
    localparam int LC_W = $clog2(LOCK_CNT + 1);

    localparam logic [ERR_W-1:0]        ERR_MAX  = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic [ERR_W-1:0]        CNT_ONE  = ERR_W'(1);
    localparam logic [ERR_W-1:0]        CNT_ZERO = ERR_W'(0);
    localparam logic [LC_W-1:0]         LC_ONE   = LC_W'(1);
    localparam logic [LC_W-1:0]         LC_FULL  = LC_W'(LOCK_CNT);
    localparam logic signed [W-1:0]     INIT_S   = {{(W-BIT_COUNT){1'b0}}, SPEED_INIT};
    localparam logic signed [W-1:0]     MIN_S    = {{(W-BIT_COUNT){1'b0}}, SPEED_MIN};
    localparam logic signed [W-1:0]     MAX_S    = {{(W-BIT_COUNT){1'b0}}, SPEED_MAX};
    localparam logic signed [W-1:0]     I_MIN_S  = MIN_S - INIT_S;
    localparam logic signed [W-1:0]     I_MAX_S  = MAX_S - INIT_S;
    localparam logic signed [W-1:0]     TOL_S    = W'(LOCK_TOL);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_FB  = 2'd1,
        WAIT_REF = 2'd2,
        UPDATE   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic                    ref_prev_q, ref_prev_d;
    logic                    fb_prev_q, fb_prev_d;
    logic                    pend_ref_q, pend_ref_d;
    logic                    pend_fb_q, pend_fb_d;
    logic [ERR_W-1:0]        cnt_q, cnt_d;
    logic signed [ERR_W-1:0] err_q, err_d;
    logic signed [W-1:0]     integ_q, integ_d;
    logic [BIT_COUNT-1:0]    speed_q, speed_d;
    logic signed [ERR_W-1:0] phase_err_q, phase_err_d;
    logic                    upd_q, upd_d;
    logic                    locked_q, locked_d;
    logic [LC_W-1:0]         lock_cnt_q, lock_cnt_d;

    logic                    ref_rise, fb_rise, ref_ev, fb_ev;
    logic signed [W-1:0]     err_ext, ki_term, kp_term;
    logic signed [W-1:0]     integ_sum, integ_clamped, speed_sum, err_abs;

    assign ref_rise = ref_in & ~ref_prev_q;
    assign fb_rise  = fb_in & ~fb_prev_q;
    assign ref_ev   = ref_rise | pend_ref_q;
    assign fb_ev    = fb_rise | pend_fb_q;

    assign err_ext  = {{(W-ERR_W){err_q[ERR_W-1]}}, err_q};
    assign ki_term  = err_ext <<< KI_SHIFT;
    assign kp_term  = err_ext <<< KP_SHIFT;

    // State register plus all datapath flops; reset discards any measurement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            ref_prev_q  <= 1'b0;
            fb_prev_q   <= 1'b0;
            pend_ref_q  <= 1'b0;
            pend_fb_q   <= 1'b0;
            cnt_q       <= CNT_ZERO;
            err_q       <= {ERR_W{1'b0}};
            integ_q     <= {W{1'b0}};
            speed_q     <= SPEED_INIT;
            phase_err_q <= {ERR_W{1'b0}};
            upd_q       <= 1'b0;
            locked_q    <= 1'b0;
            lock_cnt_q  <= {LC_W{1'b0}};
        end else begin
            state_q     <= state_d;
            ref_prev_q  <= ref_prev_d;
            fb_prev_q   <= fb_prev_d;
            pend_ref_q  <= pend_ref_d;
            pend_fb_q   <= pend_fb_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            integ_q     <= integ_d;
            speed_q     <= speed_d;
            phase_err_q <= phase_err_d;
            upd_q       <= upd_d;
            locked_q    <= locked_d;
            lock_cnt_q  <= lock_cnt_d;
        end
    end

    // Phase detector: next state, edge-separation counter and measured error.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        pend_ref_d = pend_ref_q;
        pend_fb_d  = pend_fb_q;
        ref_prev_d = ref_in;
        fb_prev_d  = fb_in;
        if (!en) begin
            state_d    = IDLE;
            cnt_d      = CNT_ZERO;
            pend_ref_d = 1'b0;
            pend_fb_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    pend_ref_d = 1'b0;
                    pend_fb_d  = 1'b0;
                    if (ref_ev && fb_ev) begin
                        err_d   = {ERR_W{1'b0}};
                        state_d = UPDATE;
                    end else if (ref_ev) begin
                        cnt_d   = CNT_ONE;
                        state_d = WAIT_FB;
                    end else if (fb_ev) begin
                        cnt_d   = CNT_ONE;
                        state_d = WAIT_REF;
                    end else begin
                        state_d = IDLE;
                    end
                end
                WAIT_FB: begin
                    if (fb_rise) begin
                        err_d   = cnt_q;
                        state_d = UPDATE;
                    end else if (ref_rise) begin
                        err_d   = ERR_MAX;
                        state_d = UPDATE;
                    end else if (cnt_q != ERR_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                WAIT_REF: begin
                    if (ref_rise) begin
                        err_d   = CNT_ZERO - cnt_q;
                        state_d = UPDATE;
                    end else if (fb_rise) begin
                        err_d   = CNT_ZERO - ERR_MAX;
                        state_d = UPDATE;
                    end else if (cnt_q != ERR_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                UPDATE: begin
                    // Edges landing in the update cycle are replayed from IDLE.
                    pend_ref_d = pend_ref_q | ref_rise;
                    pend_fb_d  = pend_fb_q | fb_rise;
                    state_d    = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // PI filter with anti-windup clamp, output update pulse and lock tracking.
    always_comb begin
        integ_d       = integ_q;
        speed_d       = speed_q;
        phase_err_d   = phase_err_q;
        upd_d         = 1'b0;
        locked_d      = locked_q;
        lock_cnt_d    = lock_cnt_q;
        integ_sum     = integ_q + ki_term;
        err_abs       = err_ext[W-1] ? -err_ext : err_ext;
        // Integrator is bounded so that INIT+integ alone never leaves the range.
        if (integ_sum < I_MIN_S) begin
            integ_clamped = I_MIN_S;
        end else if (integ_sum > I_MAX_S) begin
            integ_clamped = I_MAX_S;
        end else begin
            integ_clamped = integ_sum;
        end
        speed_sum = INIT_S + integ_clamped + kp_term;
        if (!en) begin
            locked_d   = 1'b0;
            lock_cnt_d = {LC_W{1'b0}};
        end else if (state_q == UPDATE) begin
            integ_d     = integ_clamped;
            phase_err_d = err_q;
            upd_d       = 1'b1;
            if (speed_sum < MIN_S) begin
                speed_d = SPEED_MIN;
            end else if (speed_sum > MAX_S) begin
                speed_d = SPEED_MAX;
            end else begin
                speed_d = speed_sum[BIT_COUNT-1:0];
            end
            if (err_abs <= TOL_S) begin
                if (lock_cnt_q != LC_FULL) begin
                    lock_cnt_d = lock_cnt_q + LC_ONE;
                end else begin
                    lock_cnt_d = lock_cnt_q;
                end
                locked_d = (lock_cnt_d == LC_FULL);
            end else begin
                lock_cnt_d = {LC_W{1'b0}};
                locked_d   = 1'b0;
            end
        end else begin
            upd_d = 1'b0;
        end
    end

    assign speed_var = speed_q;
    assign upd       = upd_q;
    assign phase_err = phase_err_q;
    assign locked    = locked_q;

endmodule

// File: tb/tb_pll_loop_ctrl.sv
// Scoreboard bench for pll_loop_ctrl: each measurement pushes the expected
// error/tuning word/lock state with its due cycle; every upd pulse pops one.
module tb_pll_loop_ctrl;

    logic               clk = 1'b0;
    logic               rst;
    logic               en;
    logic               ref_in;
    logic               fb_in;
    logic [23:0]        speed_var;
    logic               upd;
    logic signed [15:0] phase_err;
    logic               locked;

    pll_loop_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .ref_in    (ref_in),
        .fb_in     (fb_in),
        .speed_var (speed_var),
        .upd       (upd),
        .phase_err (phase_err),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint err;
        longint speed;
        longint lk;
        int     due;
    } exp_t;

    exp_t   sb_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc   = 0;
    longint m_integ;
    longint m_speed;
    int     m_lcnt;

    // Free-running cycle number used to check output latency.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic model_reset();
        m_integ = 0;
        m_speed = 64'h100000;
        m_lcnt  = 0;
    endtask

    // Independent PI/lock model; pushes the expectation for one update.
    task automatic push_exp(input longint err, input int due);
        exp_t   e;
        longint integ;
        longint sp;
        integ = m_integ + err * 16;
        if (integ < 64'sh10000 - 64'sh100000) integ = 64'sh10000 - 64'sh100000;
        if (integ > 64'sh7FFFFF - 64'sh100000) integ = 64'sh7FFFFF - 64'sh100000;
        sp = 64'sh100000 + integ + err * 256;
        if (sp < 64'sh10000) sp = 64'sh10000;
        if (sp > 64'sh7FFFFF) sp = 64'sh7FFFFF;
        m_integ = integ;
        m_speed = sp;
        if (err <= 2 && err >= -2) begin
            if (m_lcnt < 16) m_lcnt++;
        end else begin
            m_lcnt = 0;
        end
        e.err   = err;
        e.speed = sp;
        e.lk    = (m_lcnt == 16) ? 1 : 0;
        e.due   = due;
        sb_q.push_back(e);
    endtask

    // Scoreboard side: every upd pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (upd) begin
            if (sb_q.size() == 0) begin
                check("upd_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("upd_latency", cyc, e.due);
                check("phase_err", phase_err, e.err);
                check("speed_var", speed_var, e.speed);
                check("locked", locked, e.lk);
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        check("drain_timeout", sb_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // k>0: ref then fb k cycles later; k<0: fb then ref; k==0: together.
    task automatic meas(input int k);
        int m;
        m = (k < 0) ? -k : k;
        @(negedge clk);
        if (k == 0) begin
            ref_in = 1'b1;
            fb_in  = 1'b1;
            push_exp(0, cyc + 2);
        end else begin
            if (k > 0) ref_in = 1'b1;
            else       fb_in  = 1'b1;
            for (int i = 1; i <= m; i++) begin
                @(negedge clk);
                ref_in = 1'b0;
                fb_in  = 1'b0;
                if (i == m) begin
                    if (k > 0) fb_in  = 1'b1;
                    else       ref_in = 1'b1;
                    push_exp(k, cyc + 2);
                end
            end
        end
        @(negedge clk);
        ref_in = 1'b0;
        fb_in  = 1'b0;
        drain();
    endtask

    // Two ref edges with no feedback in between: positive cycle slip.
    task automatic slip();
        @(negedge clk);
        ref_in = 1'b1;
        @(negedge clk);
        ref_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ref_in = 1'b1;
        push_exp(32767, cyc + 2);
        @(negedge clk);
        ref_in = 1'b0;
        drain();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_speed", speed_var, 24'h100000);
        check("rst_upd", upd, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [23:0] held;
        rst    = 1'b1;
        en     = 1'b1;
        ref_in = 1'b0;
        fb_in  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_speed", speed_var, 24'h100000);
        check("reset_upd", upd, 0);
        check("reset_locked", locked, 0);
        check("reset_phase_err", phase_err, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        meas(0);
        check("coincident_speed", speed_var, 24'h100000);
        meas(3);
        check("ref_lead3_speed", speed_var, 24'h100330);

        do_reset();
        meas(-5);
        check("fb_lead5_speed", speed_var, 24'h0FFAB0);
        meas(1);
        meas(-2);
        meas(7);

        for (int i = 0; i < 15; i++) slip();
        check("slip_err", phase_err, 32767);
        check("slip_speed_pinned", speed_var, 24'h7FFFFF);
        meas(-1);
        check("unwind_immediate", (speed_var < 24'h7FFFFF) ? 1 : 0, 1);

        meas(4);
        for (int i = 0; i < 16; i++) meas((i % 5) - 2);
        check("lock_after_16", locked, 1);
        meas(3);
        check("unlock_err3", locked, 0);

        for (int i = 0; i < 16; i++) meas((i % 3) - 1);
        check("relock", locked, 1);
        held = speed_var;
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        m_lcnt = 0;
        check("en_off_locked", locked, 0);
        check("en_off_speed_hold", speed_var, held);
        repeat (2) @(negedge clk);

        @(negedge clk);
        ref_in = 1'b1;
        @(negedge clk);
        ref_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_speed", speed_var, 24'h100000);
        check("midrst_locked", locked, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (8) @(negedge clk);
        check("midrst_phase_err", phase_err, 0);
        meas(2);

        check("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pll_loop_ctrl.md
Name: pll_loop_ctrl

Overview:
Digital phase detector plus PI loop filter that closes the PLL around the DCO. It compares rising edges of a reference input against the DCO feedback output. Edge-to-edge separation is measured in clk cycles as a signed phase error. A saturating PI filter turns that error into the DCO tuning word speed_var, with one update per reference/feedback edge pair. It also reports lock status.

Parameters:
BIT_COUNT, 24, width of speed_var; matches the DCO tuning word width.
ERR_W, 16, signed phase-error width; magnitude saturates at 2^(ERR_W-1)-1.
KP_SHIFT, 8, proportional gain; P term = err * 2^KP_SHIFT.
KI_SHIFT, 4, integral gain; the integrator accumulates err * 2^KI_SHIFT per update.
SPEED_INIT, 24'h100000, tuning word after reset.
SPEED_MIN, 24'h010000, lower clamp for speed_var.
SPEED_MAX, 24'h7FFFFF, upper clamp for speed_var.
LOCK_TOL, 2, maximum |err| that counts as an in-lock update.
LOCK_CNT, 16, consecutive in-lock updates required to assert locked.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
en  in  1  loop enable
ref_in  in  1  reference, already synchronous to clk
fb_in  in  1  DCO signal_out (registered, clk domain)
speed_var  out  BIT_COUNT  DCO tuning word
upd  out  1  one-cycle pulse when speed_var/phase_err change
phase_err  out  ERR_W signed  last measured error (+ = feedback late)
locked  out  1  lock indicator

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset: speed_var=SPEED_INIT, upd=0, phase_err=0, locked=0, integrator=0, lock counter=0, cycle counter=0, pending flags=0, state=IDLE, edge-history registers=0.
- Edge detection: rise = current & ~previous, using the previous-cycle value. An input high on the first cycle after reset counts as an edge.
- FSM states: IDLE, WAIT_FB, WAIT_REF, UPDATE.
- IDLE, edge handling:
  - ref rise and fb rise in the same cycle -> err=0, go to UPDATE.
  - ref rise only -> cnt=1, go to WAIT_FB.
  - fb rise only -> cnt=1, go to WAIT_REF.
  - Pending flags are treated as edges in this cycle.
- WAIT_FB:
  - fb rise -> err=+cnt, go to UPDATE. fb rise has priority if ref rises in the same cycle.
  - ref rise without fb (cycle slip) -> err=+max, go to UPDATE.
  - Otherwise cnt increments, saturating at 2^(ERR_W-1)-1.
  - Net result: ref at cycle t and fb at t+k gives err=+k.
- WAIT_REF: mirror of WAIT_FB with negative sign; cycle slip gives err=-max.
- UPDATE (one cycle):
  - All arithmetic is signed, at BIT_COUNT+ERR_W+2 bits.
  - integ_next = integ + err*2^KI_SHIFT, clamped so SPEED_INIT+integ_next stays in [SPEED_MIN, SPEED_MAX] (anti-windup).
  - speed_var <= clamp(SPEED_INIT + integ_next + err*2^KP_SHIFT, SPEED_MIN, SPEED_MAX).
  - phase_err <= err; upd <= 1 for exactly one cycle.
  - Edges arriving during UPDATE set pending flags, then return to IDLE.
- Latency: terminating edge at cycle t -> speed_var, phase_err and upd are valid at t+2.
- Lock: evaluated on each UPDATE.
  - |err| <= LOCK_TOL -> lock counter increments, saturating at LOCK_CNT; locked=1 when it reaches LOCK_CNT.
  - Otherwise lock counter=0 and locked=0, effective with the same upd.
- en=0:
  - FSM forced to IDLE; cnt and pending flags cleared; upd=0; locked=0; lock counter=0.
  - speed_var and integrator hold their values.
  - Edge history keeps tracking, so re-enable does not produce spurious edges.
- Reset mid-measurement: all state is discarded immediately; no upd pulse.

Test Plan:
- Release rst with inputs low -> speed_var=0x100000, upd=0, locked=0, phase_err=0.
- ref rise at cycle t, fb rise at t+3 -> phase_err=+3 and speed_var=0x100000+768+48=0x100330 at t+5; upd high for that cycle only.
- ref and fb rise in the same cycle from reset -> phase_err=0, speed_var stays 0x100000, upd pulses once.
- fb rise at t, ref rise at t+5 -> phase_err=-5, speed_var=0x100000-1280-80=0x0FFAB0.
- Windup and slip:
  - Repeated ref-only edges (cycle slips) -> phase_err=+32767 and speed_var pinned at 0x7FFFFF.
  - A following err=-1 update drops speed_var below 0x7FFFFF immediately, with no integrator unwind delay.
- Lock:
  - 16 consecutive updates with |err|<=2 -> locked rises with the 16th upd.
  - A following err=3 -> locked falls with that upd.
  - Deasserting en for 1 cycle -> locked=0 and speed_var unchanged.
